gclk_en_sched: RTL and testbench
================================

GCLK_EN_SCHED -- requirements
Module: gclk_en_sched

Interface
REQ-001 SHALL provide parameter N_ENT, default 8: number of gated-clock entries.
REQ-002 SHALL provide parameter HOLD_CYC, default 4: idle cycles an entry stays enabled after its last activity; legal range 1..255.
REQ-003 SHALL provide parameter MAX_ACT, default 4: maximum simultaneously enabled entries; legal range 1..N_ENT.
REQ-004 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its posedge.
REQ-005 SHALL provide port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL provide port req, input, N_ENT bits: per-entry wake request, held high until ack or withdrawn.
REQ-007 SHALL provide port busy, input, N_ENT bits: per-entry activity; keeps an enabled entry alive.
REQ-008 SHALL provide port en_e1, output, N_ENT bits: registered clock-enable, one cycle ahead of the negative-level enable latch feeding the clock-gate AND.
REQ-009 SHALL provide port ack, output, N_ENT bits: one-cycle pulse on the grant of an entry.
REQ-010 SHALL provide port active_cnt, output, clog2(N_ENT+1) bits: number of set en_e1 bits.

Function
REQ-011 SHALL keep each entry in state OFF, ON or DRAIN.
REQ-012 SHALL move an entry from OFF to ON when it is granted; en_e1[i] and ack[i] rise in the cycle after req[i] is sampled high with the grant.
REQ-013 SHALL grant at most one OFF entry per cycle, chosen round-robin starting after the most recently granted index; the pointer advances only on a grant.
REQ-014 SHALL, in ON, reload the entry's hold counter with HOLD_CYC while busy[i] or req[i] is high, and move to DRAIN on the first cycle both are low.
REQ-015 SHALL, in DRAIN, decrement the hold counter each cycle and return to ON with a reload if busy[i] or req[i] rises.
REQ-016 SHALL move DRAIN to OFF when the counter reaches 0; en_e1[i] falls on that same edge.
REQ-017 SHALL keep en_e1[i] high in both ON and DRAIN and low in OFF.
REQ-018 SHALL treat req[i] dropped before ack as a withdrawal with no grant and no pointer change.
REQ-019 SHALL ignore req[i] for an entry already in ON or DRAIN for arbitration; it acts only as activity.
REQ-020 SHALL compute active_cnt from registered state; a slot freed by an ON/DRAIN-to-OFF transition is grantable one cycle later, never in the same cycle.
REQ-021 SHALL never allow the hold counter to underflow or wrap.

Reset
REQ-022 SHALL, while rst is high, force all entries to OFF, en_e1=0, ack=0, active_cnt=0, all hold counters to 0 and the round-robin pointer to index N_ENT-1, so that index 0 has first priority.
REQ-023 SHALL, on rst asserted mid-operation, clear en_e1 asynchronously and resume arbitration at the first posedge after rst deasserts.

Configuration
REQ-024 SHALL, with GCLK_SCHED_BUDGET_EN defined, withhold grants while active_cnt equals MAX_ACT.
REQ-025 SHALL, without GCLK_SCHED_BUDGET_EN, ignore MAX_ACT and still grant at most one entry per cycle.

Structure
REQ-026 SHALL place the entry state enum (OFF/ON/DRAIN), default parameter constants and the hold-counter width typedef in the shared package gclk_sched_pkg.
REQ-027 SHALL implement arbitration in one sub-module rr_arb, a parameterised round-robin single-grant arbiter with request, grant and enable ports.

Verification
REQ-028 SHALL cover: reset released, req=8'h01 at cycle 2 -> ack[0] and en_e1[0] high at cycle 3; busy low -> en_e1[0] low at cycle 3+1+HOLD_CYC=8.
REQ-029 SHALL cover: req=8'hFF held from reset release -> acks in order 0,1,2,... one per cycle; with the budget macro, grants stop after 4 and active_cnt=4.
REQ-030 SHALL cover: entry 2 in DRAIN, counter 2, busy[2] pulsed -> state ON, counter reloaded to 4, en_e1[2] never drops.
REQ-031 SHALL cover: budget full, entry 1 reaches OFF at cycle t with entry 5 requesting -> ack[5] at t+1, not at t.
REQ-032 SHALL cover: req[3] high for one cycle while blocked, then dropped -> no ack[3] and pointer unchanged.
REQ-033 SHALL cover: rst pulsed while en_e1=8'h0F -> en_e1=0 immediately, the first post-reset grant goes to the lowest pending index, and gated-clock flops capture d from before each gated posedge.

Source files
------------

// File: rtl/gclk_sched_pkg.sv
// Shared types and constants for the gated-clock enable scheduler.
// Holds the per-entry state encoding, the default parameter values and the
// hold-counter type used by gclk_en_sched and its arbiter.
package gclk_sched_pkg;

    // Per-entry life cycle: OFF (clock gated), ON (active), DRAIN (idle, counting down).
    typedef enum logic [1:0] {
        ENT_OFF   = 2'd0,
        ENT_ON    = 2'd1,
        ENT_DRAIN = 2'd2
    } ent_state_t;

    localparam int DEF_N_ENT    = 8;
    localparam int DEF_HOLD_CYC = 4;
    localparam int DEF_MAX_ACT  = 4;

    // Wide enough for the largest legal hold time (255).
    localparam int HOLD_W = 8;
    typedef logic [HOLD_W-1:0] hold_cnt_t;

    // Index width for a vector of n entries; never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gclk_en_sched_rr_arb.sv
// rr_arb: round-robin single-grant arbiter.
// Searches from the index after the most recent grant, wrapping around.
// The pointer moves only when a grant is actually issued (i_en high and a
// request present), so withdrawn or blocked requests leave it untouched.
module rr_arb
    import gclk_sched_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    output logic [N-1:0] o_gnt
);

    localparam int PW = idx_width(N);

    logic [PW-1:0] r_ptr;
    logic [N-1:0]  w_pick;
    logic [PW-1:0] w_sel;
    logic [PW-1:0] w_pos;
    logic          w_found;
    int            w_idx;

    // First requester found walking upward from r_ptr+1 with wrap-around.
    always_comb begin
        w_pick  = '0;
        w_sel   = '0;
        w_pos   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= N; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            w_pos = PW'(w_idx);
            if (!w_found && i_req[w_pos]) begin
                w_pick[w_pos] = 1'b1;
                w_sel         = w_pos;
                w_found       = 1'b1;
            end
        end
    end

    assign o_gnt = i_en ? w_pick : '0;

    // Pointer starts at the top index so index 0 has first priority after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= PW'(N - 1);
        end else if (i_en && w_found) begin
            r_ptr <= w_sel;
        end
    end

endmodule

// File: rtl/gclk_en_sched.sv
// gclk_en_sched: gated-clock enable scheduler.
// Each entry wakes on a granted request, stays enabled while busy/req is
// seen, and holds its enable for HOLD_CYC idle cycles before gating off.
// en_e1 is registered one cycle ahead of the downstream negative-level
// enable latch that feeds the clock-gate AND.
// Optional feature: define GCLK_SCHED_BUDGET_EN to cap the number of
// simultaneously enabled entries at MAX_ACT.
module gclk_en_sched
    import gclk_sched_pkg::*;
#(
    parameter int N_ENT    = DEF_N_ENT,
    parameter int HOLD_CYC = DEF_HOLD_CYC,
    parameter int MAX_ACT  = DEF_MAX_ACT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_ENT-1:0]           req,
    input  logic [N_ENT-1:0]           busy,
    output logic [N_ENT-1:0]           en_e1,
    output logic [N_ENT-1:0]           ack,
    output logic [$clog2(N_ENT+1)-1:0] active_cnt
);

    localparam int        CW       = $clog2(N_ENT + 1);
    localparam hold_cnt_t HOLD_VAL = hold_cnt_t'(HOLD_CYC);

    // Reject illegal configurations at elaboration.
    if (HOLD_CYC < 1 || HOLD_CYC > 255) begin : g_bad_hold
        $error("gclk_en_sched: HOLD_CYC out of range 1..255");
    end
    if (MAX_ACT < 1 || MAX_ACT > N_ENT) begin : g_bad_max_act
        $error("gclk_en_sched: MAX_ACT out of range 1..N_ENT");
    end

    logic [N_ENT-1:0] w_off;
    logic [N_ENT-1:0] w_arb_req;
    logic [N_ENT-1:0] w_gnt;
    logic [N_ENT-1:0] w_en;
    logic [N_ENT-1:0] w_ack;
    logic [CW-1:0]    w_active_cnt;
    logic             w_arb_en;

    // Only OFF entries compete; req on ON/DRAIN entries is just activity.
    assign w_arb_req = req & w_off;

    rr_arb #(
        .N (N_ENT)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (w_arb_req),
        .i_en  (w_arb_en),
        .o_gnt (w_gnt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_ENT; gi++) begin : g_ent
            ent_state_t r_state;
            ent_state_t w_state_next;
            hold_cnt_t  r_cnt;
            hold_cnt_t  w_cnt_next;
            logic       r_en;
            logic       r_ack;
            logic       w_act;

            assign w_act = busy[gi] | req[gi];

            // Next-state and hold-counter update; the counter saturates at 0.
            always_comb begin
                w_state_next = r_state;
                w_cnt_next   = r_cnt;
                case (r_state)
                    ENT_OFF: begin
                        if (w_gnt[gi]) begin
                            w_state_next = ENT_ON;
                            w_cnt_next   = HOLD_VAL;
                        end
                    end
                    ENT_ON: begin
                        if (w_act) begin
                            w_cnt_next = HOLD_VAL;
                        end else begin
                            w_state_next = ENT_DRAIN;
                        end
                    end
                    ENT_DRAIN: begin
                        if (w_act) begin
                            w_state_next = ENT_ON;
                            w_cnt_next   = HOLD_VAL;
                        end else if (r_cnt <= hold_cnt_t'(1)) begin
                            w_state_next = ENT_OFF;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt - hold_cnt_t'(1);
                        end
                    end
                    default: begin
                        w_state_next = ENT_OFF;
                        w_cnt_next   = '0;
                    end
                endcase
            end

            // State, counter, enable and ack registers; enable follows next state
            // so it falls on the same edge the entry reaches OFF.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state <= ENT_OFF;
                    r_cnt   <= '0;
                    r_en    <= 1'b0;
                    r_ack   <= 1'b0;
                end else begin
                    r_state <= w_state_next;
                    r_cnt   <= w_cnt_next;
                    r_en    <= (w_state_next != ENT_OFF);
                    r_ack   <= w_gnt[gi];
                end
            end

            assign w_off[gi] = (r_state == ENT_OFF);
            assign w_en[gi]  = r_en;
            assign w_ack[gi] = r_ack;
        end
    endgenerate

    // Population count of the registered enables.
    always_comb begin
        w_active_cnt = '0;
        for (int i = 0; i < N_ENT; i++) begin
            w_active_cnt = w_active_cnt + CW'(w_en[i]);
        end
    end

`ifdef GCLK_SCHED_BUDGET_EN
    // Hold off grants once the enable budget is used up.
    assign w_arb_en = (int'(w_active_cnt) < MAX_ACT);
`else
    assign w_arb_en = 1'b1;
`endif

    assign en_e1      = w_en;
    assign ack        = w_ack;
    assign active_cnt = w_active_cnt;

endmodule

// File: tb/tb_gclk_en_sched.sv
// Directed self-checking bench for gclk_en_sched (N_ENT=8, HOLD_CYC=4, MAX_ACT=4).
// Expectations follow GCLK_SCHED_BUDGET_EN when it is defined for the build.
module tb_gclk_en_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] busy = 8'h00;
    logic [7:0] en_e1;
    logic [7:0] ack;
    logic [3:0] active_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gclk_en_sched #(
        .N_ENT    (8),
        .HOLD_CYC (4),
        .MAX_ACT  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .busy       (busy),
        .en_e1      (en_e1),
        .ack        (ack),
        .active_cnt (active_cnt)
    );

    // Clock-gate model for entry 0: negative-level latch then AND.
    logic       l_en;
    logic       gclk;
    logic [7:0] d_val = 8'h00;
    logic [7:0] g_q = 8'h00;

    always_latch begin
        if (!clk) l_en <= en_e1[0];
    end
    assign gclk = clk & l_en;
    always @(negedge clk) d_val <= d_val + 8'd1;
    always @(posedge gclk) g_q <= d_val;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 8'h00;
        busy = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_tests++; if (en_e1 !== 8'h00) begin n_fail++; $display("FAIL reset_en: got %h want %h", en_e1, 8'h00); end
        n_tests++; if (ack !== 8'h00) begin n_fail++; $display("FAIL reset_ack: got %h want %h", ack, 8'h00); end
        n_tests++; if (active_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", active_cnt); end
        req = 8'hFF;
        tick();
        n_tests++; if (ack !== 8'h00) begin n_fail++; $display("FAIL reset_hold_ack: got %h want %h", ack, 8'h00); end
        n_tests++; if (en_e1 !== 8'h00) begin n_fail++; $display("FAIL reset_hold_en: got %h want %h", en_e1, 8'h00); end
        req = 8'h00;
        rst = 1'b0;
        $display("[TB] reset checked");
    endtask

    task automatic test_single();
        tick();
        req = 8'h01;
        tick();
        n_tests++; if (ack !== 8'h01) begin n_fail++; $display("FAIL single_ack: got %h want %h", ack, 8'h01); end
        n_tests++; if (en_e1 !== 8'h01) begin n_fail++; $display("FAIL single_en: got %h want %h", en_e1, 8'h01); end
        n_tests++; if (active_cnt !== 4'd1) begin n_fail++; $display("FAIL single_cnt: got %0d want 1", active_cnt); end
        req = 8'h00;
        for (int j = 0; j < 4; j++) begin
            tick();
            n_tests++; if (en_e1 !== 8'h01) begin n_fail++; $display("FAIL single_hold%0d: got %h want %h", j, en_e1, 8'h01); end
        end
        n_tests++; if (ack !== 8'h00) begin n_fail++; $display("FAIL single_ack_pulse: got %h want %h", ack, 8'h00); end
        tick();
        n_tests++; if (en_e1 !== 8'h00) begin n_fail++; $display("FAIL single_off: got %h want %h", en_e1, 8'h00); end
        n_tests++; if (active_cnt !== 4'd0) begin n_fail++; $display("FAIL single_off_cnt: got %0d want 0", active_cnt); end
        $display("[TB] single wake/drain done");
    endtask

    task automatic test_all_req();
        logic [7:0] e_ack;
        logic [3:0] e_cnt;
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 6; k++) begin
            tick();
            e_ack = 8'h01 << k;
            e_cnt = 4'(k + 1);
`ifdef GCLK_SCHED_BUDGET_EN
            if (k >= 4) e_ack = 8'h00;
            if (k >= 4) e_cnt = 4'd4;
`endif
            n_tests++; if (ack !== e_ack) begin n_fail++; $display("FAIL all_ack%0d: got %h want %h", k, ack, e_ack); end
            if (k <= 4) begin
                n_tests++; if (active_cnt !== e_cnt) begin n_fail++; $display("FAIL all_cnt%0d: got %0d want %0d", k, active_cnt, e_cnt); end
            end
            $display("[TB] all_req step %0d ack=%h en=%h", k, ack, en_e1);
            req = req & ~e_ack;
        end
        req = 8'h00;
        repeat (20) tick();
        n_tests++; if (en_e1 !== 8'h00) begin n_fail++; $display("FAIL all_idle: got %h want %h", en_e1, 8'h00); end
    endtask

    task automatic test_drain_reload();
        req = 8'h04;
        tick();
        n_tests++; if (ack !== 8'h04) begin n_fail++; $display("FAIL drain_ack: got %h want %h", ack, 8'h04); end
        req = 8'h00;
        for (int j = 1; j <= 3; j++) begin
            tick();
            n_tests++; if (en_e1[2] !== 1'b1) begin n_fail++; $display("FAIL drain_pre%0d: got %b want 1", j, en_e1[2]); end
        end
        busy = 8'h04;
        tick();
        n_tests++; if (en_e1[2] !== 1'b1) begin n_fail++; $display("FAIL drain_reload: got %b want 1", en_e1[2]); end
        n_tests++; if (ack !== 8'h00) begin n_fail++; $display("FAIL drain_no_ack: got %h want %h", ack, 8'h00); end
        busy = 8'h00;
        for (int j = 5; j <= 8; j++) begin
            tick();
            n_tests++; if (en_e1[2] !== 1'b1) begin n_fail++; $display("FAIL drain_post%0d: got %b want 1", j, en_e1[2]); end
        end
        tick();
        n_tests++; if (en_e1[2] !== 1'b0) begin n_fail++; $display("FAIL drain_off: got %b want 0", en_e1[2]); end
        $display("[TB] drain reload done");
        repeat (5) tick();
    endtask

    task automatic test_budget_free();
        logic [7:0] e_ack;
        do_reset();
        busy = 8'h0D;
        req  = 8'h0F;
        for (int k = 0; k < 4; k++) begin
            tick();
            e_ack = 8'h01 << k;
            n_tests++; if (ack !== e_ack) begin n_fail++; $display("FAIL budget_fill%0d: got %h want %h", k, ack, e_ack); end
            req = req & ~e_ack;
        end
        req = 8'h20;
`ifdef GCLK_SCHED_BUDGET_EN
        for (int j = 4; j <= 5; j++) begin
            tick();
            n_tests++; if (ack !== 8'h00) begin n_fail++; $display("FAIL budget_block%0d: got %h want %h", j, ack, 8'h00); end
        end
        tick();
        n_tests++; if (en_e1[1] !== 1'b0) begin n_fail++; $display("FAIL budget_e1_off: got %b want 0", en_e1[1]); end
        n_tests++; if (ack !== 8'h00) begin n_fail++; $display("FAIL budget_same_cycle: got %h want %h", ack, 8'h00); end
        n_tests++; if (active_cnt !== 4'd3) begin n_fail++; $display("FAIL budget_cnt: got %0d want 3", active_cnt); end
        tick();
        n_tests++; if (ack !== 8'h20) begin n_fail++; $display("FAIL budget_grant5: got %h want %h", ack, 8'h20); end
`else
        tick();
        n_tests++; if (ack !== 8'h20) begin n_fail++; $display("FAIL nobudget_grant5: got %h want %h", ack, 8'h20); end
`endif
        $display("[TB] budget release done");
        req  = 8'h00;
        busy = 8'h00;
        repeat (20) tick();
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 8'h09;
        tick();
        n_tests++; if (ack !== 8'h01) begin n_fail++; $display("FAIL wd_ack0: got %h want %h", ack, 8'h01); end
        req = 8'h00;
        for (int j = 0; j < 3; j++) begin
            tick();
            n_tests++; if (ack !== 8'h00) begin n_fail++; $display("FAIL wd_no_ack%0d: got %h want %h", j, ack, 8'h00); end
        end
        req = 8'h14;
        tick();
        n_tests++; if (ack !== 8'h04) begin n_fail++; $display("FAIL wd_ptr_first: got %h want %h", ack, 8'h04); end
        req = 8'h10;
        tick();
        n_tests++; if (ack !== 8'h10) begin n_fail++; $display("FAIL wd_ptr_second: got %h want %h", ack, 8'h10); end
        req = 8'h00;
        $display("[TB] withdraw done");
        repeat (20) tick();
    endtask

    task automatic test_reset_mid();
        logic [7:0] e_ack;
        logic [7:0] saved_q;
        do_reset();
        busy = 8'h0F;
        req  = 8'h0F;
        for (int k = 0; k < 4; k++) begin
            tick();
            e_ack = 8'h01 << k;
            req = req & ~e_ack;
        end
        n_tests++; if (en_e1 !== 8'h0F) begin n_fail++; $display("FAIL mid_fill: got %h want %h", en_e1, 8'h0F); end
        n_tests++; if (g_q !== d_val) begin n_fail++; $display("FAIL mid_gclk_capture: got %h want %h", g_q, d_val); end
        #2;
        rst = 1'b1;
        #1;
        n_tests++; if (en_e1 !== 8'h00) begin n_fail++; $display("FAIL mid_async_en: got %h want %h", en_e1, 8'h00); end
        n_tests++; if (active_cnt !== 4'd0) begin n_fail++; $display("FAIL mid_async_cnt: got %0d want 0", active_cnt); end
        saved_q = g_q;
        busy = 8'h00;
        req  = 8'h28;
        tick();
        n_tests++; if (g_q !== saved_q) begin n_fail++; $display("FAIL mid_gclk_stopped: got %h want %h", g_q, saved_q); end
        rst = 1'b0;
        tick();
        n_tests++; if (ack !== 8'h08) begin n_fail++; $display("FAIL mid_first_grant: got %h want %h", ack, 8'h08); end
        n_tests++; if (en_e1 !== 8'h08) begin n_fail++; $display("FAIL mid_first_en: got %h want %h", en_e1, 8'h08); end
        req = 8'h20;
        tick();
        n_tests++; if (ack !== 8'h20) begin n_fail++; $display("FAIL mid_second_grant: got %h want %h", ack, 8'h20); end
        req = 8'h00;
        $display("[TB] mid-operation reset done");
        repeat (20) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_req();
        test_drain_reload();
        test_budget_free();
        test_withdraw();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
